// File: rtl/extbus_pkg.sv
// Shared definitions for the external-bus register file: port indices,
// default word layout and field-select helpers.
package extbus_pkg;

    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;
    localparam int unsigned PORT_C = 2;
    localparam int unsigned PORT_X = 3;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_TAG_W  = 8;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_NPORTS = 4;

    // Default word layout: tag sits above data
    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } word_def_t;

    typedef enum logic {
        FLD_DATA = 1'b0,
        FLD_TAG  = 1'b1
    } field_e;

    // Select the enable belonging to a given field
    function automatic logic fld_en(field_e fld, logic en_data, logic en_tag);
        return (fld == FLD_TAG) ? en_tag : en_data;
    endfunction

endpackage

// File: rtl/extbus_rf_if.sv
// Multi-port access bundle between the processor buses and the register file.
interface extbus_rf_if #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned AW     = 2,
    parameter int unsigned WW     = 72
);
    logic [NPORTS*AW-1:0] addr;
    logic [NPORTS-1:0]    en_data;
    logic [NPORTS-1:0]    en_tag;
    logic [NPORTS-1:0]    we;
    logic [NPORTS*WW-1:0] wdata;
    logic                 clr_collision;
    logic [NPORTS*WW-1:0] rdata;
    logic [NPORTS-1:0]    rvalid;
    logic [NPORTS-1:0]    collision;

    modport master (
        output addr, en_data, en_tag, we, wdata, clr_collision,
        input  rdata, rvalid, collision
    );

    modport slave (
        input  addr, en_data, en_tag, we, wdata, clr_collision,
        output rdata, rvalid, collision
    );
endinterface

// File: rtl/extbus_wsel.sv
// Write-priority selector for one field of one word: highest requesting port wins.
module extbus_wsel #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned PW     = 2
) (
    input  logic [NPORTS-1:0] req,
    output logic [PW-1:0]     win_c,
    output logic              wen_c,
    output logic [NPORTS-1:0] lose_c
);

    // Pick the winner, then flag every other requester as a loser
    always_comb begin
        win_c  = '0;
        wen_c  = 1'b0;
        lose_c = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (req[p]) begin
                win_c = PW'(p);
                wen_c = 1'b1;
            end
        end
        for (int p = 0; p < NPORTS; p++) begin
            lose_c[p] = req[p] && !(wen_c && (win_c == PW'(p)));
        end
    end

endmodule

// File: rtl/extbus_rf.sv
// Parametrised multi-port register file with per-field enables, write-first
// reads, write-through and sticky collision reporting.
module extbus_rf
    import extbus_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NPORTS = DEF_NPORTS
) (
    input  logic       clk,
    input  logic       reset,
    extbus_rf_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = DATA_W + TAG_W;
    localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [WW-1:0]     mem      [DEPTH];
    logic [WW-1:0]     mem_nxt  [DEPTH];
    logic [AW-1:0]     pa       [NPORTS];
    logic [NPORTS-1:0] act;
    logic [NPORTS-1:0] inr;
    logic [NPORTS-1:0] wr;

    logic [DEPTH-1:0][PW-1:0]     dwin, twin;
    logic [DEPTH-1:0]             dwen, twen;
    logic [DEPTH-1:0][NPORTS-1:0] dlose, tlose;
    logic [NPORTS-1:0]            lose_any;

    logic [NPORTS*WW-1:0] rdata_q, rdata_nxt;
    logic [NPORTS-1:0]    rvalid_q;
    logic [NPORTS-1:0]    coll_q;

    // Per-port address decode, activity and range qualification
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            pa[p]  = bus.addr[p*AW +: AW];
            act[p] = bus.en_data[p] | bus.en_tag[p];
            inr[p] = 32'(pa[p]) < DEPTH;
            wr[p]  = act[p] & bus.we[p] & inr[p];
        end
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic [NPORTS-1:0] dreq, treq;

        // Writers targeting this word, split by field
        always_comb begin
            dreq = '0;
            treq = '0;
            for (int p = 0; p < NPORTS; p++) begin
                if (wr[p] && (pa[p] == AW'(w))) begin
                    dreq[p] = fld_en(FLD_DATA, bus.en_data[p], bus.en_tag[p]);
                    treq[p] = fld_en(FLD_TAG, bus.en_data[p], bus.en_tag[p]);
                end
            end
        end

        extbus_wsel #(.NPORTS(NPORTS), .PW(PW)) u_dsel (
            .req(dreq), .win_c(dwin[w]), .wen_c(dwen[w]), .lose_c(dlose[w])
        );

        extbus_wsel #(.NPORTS(NPORTS), .PW(PW)) u_tsel (
            .req(treq), .win_c(twin[w]), .wen_c(twen[w]), .lose_c(tlose[w])
        );
    end

    // Post-write memory image and union of collision losers
    always_comb begin
        mem_nxt  = mem;
        lose_any = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (dwen[w]) begin
                mem_nxt[w][DATA_W-1:0] = bus.wdata[32'(dwin[w])*WW +: DATA_W];
            end
            if (twen[w]) begin
                mem_nxt[w][WW-1:DATA_W] = bus.wdata[32'(twin[w])*WW + DATA_W +: TAG_W];
            end
            lose_any = lose_any | dlose[w] | tlose[w];
        end
    end

    // Next read word: enabled fields reload from the post-write image (0 when out of range)
    always_comb begin
        logic [WW-1:0] rd;
        rd        = '0;
        rdata_nxt = rdata_q;
        for (int p = 0; p < NPORTS; p++) begin
            rd = inr[p] ? mem_nxt[pa[p]] : '0;
            if (bus.en_data[p]) begin
                rdata_nxt[p*WW +: DATA_W] = rd[DATA_W-1:0];
            end
            if (bus.en_tag[p]) begin
                rdata_nxt[p*WW + DATA_W +: TAG_W] = rd[WW-1:DATA_W];
            end
        end
    end

    // State update: memory, read registers, strobes and sticky flags (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem      <= '{default: '0};
            rdata_q  <= '0;
            rvalid_q <= '0;
            coll_q   <= '0;
        end else begin
            mem      <= mem_nxt;
            rdata_q  <= rdata_nxt;
            rvalid_q <= act;
            coll_q   <= (bus.clr_collision ? '0 : coll_q) | lose_any;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.collision = coll_q;

endmodule

// File: doc/extbus_rf.md
Name: extbus_rf

Overview:
Parametrised multi-port register file for the external bus. It replaces the fixed 4-port, 4-word, 72-bit slice array with configurable data width, tag width, depth and port count. Each port has independent data and tag enables. Read outputs are registered, with write-through and same-cycle write bypass. Colliding writes are resolved by a defined priority and reported through sticky collision flags. It sits between the processor data buses (A/B/C/X) and the external bus.

Parameters:
DATA_W, 64, data field width per word
TAG_W, 8, tag field width per word (≥1)
DEPTH, 4, number of words (≥2; need not be a power of two)
NPORTS, 4, number of ports (≥1); port index 0..NPORTS-1 maps to A, B, C, X for the default configuration
AW (localparam), $clog2(DEPTH), address width
WW (localparam), DATA_W+TAG_W, word width; tag occupies [WW-1:DATA_W]

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
addr  in  NPORTS*AW  per-port word address, port p at [p*AW +: AW]
en_data  in  NPORTS  per-port data-field enable
en_tag  in  NPORTS  per-port tag-field enable
we  in  NPORTS  per-port write enable (1=write, 0=read); ignored when both enables are 0
wdata  in  NPORTS*WW  per-port write word
rdata  out  NPORTS*WW  per-port registered read word
rvalid  out  NPORTS  per-port one-cycle strobe: rdata updated this cycle
collision  out  NPORTS  sticky per-port flag: this port lost a write collision
clr_collision  in  1  synchronous clear of all collision flags

Behaviour:
- Reset (async assert, sync to clk on release): all memory words = 0; rdata = 0; rvalid = 0; collision = 0. Operations in flight are discarded; no partial write survives.
- A port is active in a cycle when en_data|en_tag = 1. A field (data or tag) is accessed only when its enable is set. Disabled fields of rdata hold their previous value.
- Write: active port with we = 1 writes its enabled fields to mem[addr] at the clock edge.
- Write collision: two or more active writers address the same in-range word with the same field enabled. For that field the highest-index writer wins. Every losing writer sets its collision bit. Resolution is per field: a port writing only the tag never collides with a port writing only data.
- Read latency is 1 cycle. An active port with we = 0 loads its enabled fields of rdata at the edge from the post-write value of mem[addr]. This is write-first: a same-cycle write by any port, after priority resolution, is visible.
- Write-through: an active writing port also loads the resolved (winning) value of its enabled fields into its own rdata. The result can differ from its wdata if the port lost a collision.
- rvalid[p] = 1 in the cycle after port p was active, whether it read or wrote; otherwise 0.
- Out-of-range address (addr ≥ DEPTH): writes are dropped; reads load 0 into the enabled fields; rvalid still pulses. Such an access takes no part in collision resolution.
- collision bits: set on a lost collision; cleared by clr_collision. If set and clear occur in the same cycle, set wins.
- Any number of simultaneous reads to the same address is legal and returns identical data.
- No combinational path from any input to any output.

Decomposition:
- Shared package extbus_pkg: field-select helpers, port index constants PORT_A/B/C/X = 0..3, a default word-layout constant.
- Natural sub-module: extbus_wsel, one instance per field. It is purely combinational and, for a given word and field, produces the winning port index, a write-enable flag and the loser mask. The top level holds the memory array, rdata/rvalid registers and collision flags.

Test Plan:
1. Reset, then read all 4 words on every port → rdata = 0 on all ports one cycle later; rvalid = 4'b1111; collision = 0.
2. Port A writes addr 2 = 72'h5A_0123456789ABCDEF (data+tag). Next cycle port X reads addr 2 → X rdata = 72'h5A_0123456789ABCDEF, rvalid[3] = 1.
3. Same cycle: B writes addr 1 data = 64'h1111 while X writes addr 1 data = 64'h2222 (en_tag = 0) → mem data = 64'h2222; collision = 4'b0010; B rdata data field = 64'h2222; tags unchanged.
4. Same cycle: A writes addr 3 data only = 64'hAAAA; B writes addr 3 tag only = 8'hC3; C reads addr 3 both fields → C rdata = 72'hC3_000000000000AAAA next cycle; collision stays 0.
5. Set a collision bit, then assert clr_collision in the same cycle as a new collision on that port → bit remains 1; clr_collision alone next cycle → 0.
6. With DEPTH = 3: write addr 3 = all-ones, read addr 3 → rdata = 0, words 0–2 unchanged. Assert reset mid-write → all memory and outputs 0 immediately, no write committed.
